// File: rtl/shift.sv
// 32-bit registered barrel shifter: SLL, SRL and SRA with a one-cycle latency.
// Left shifts reuse the right-shift network by bit-reversing the operand and result.
module shift (
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] sh,
  input  logic [31:0] data,
  input  logic [4:0]  shift_amount,
  input  logic        right,
  input  logic        arithmetic
);

  logic            fill;
  logic [31:0]     operand;
  logic [31:0]     result;
  logic [5:0][31:0] stage;

  function automatic logic [31:0] reverse32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

  // Only an arithmetic right shift pulls in the sign; left and logical right fill with zero.
  assign fill    = data[31] & right & arithmetic;
  assign operand = right ? data : reverse32(data);
  assign stage[0] = operand;

  for (genvar k = 0; k < 5; k++) begin : g_level
    localparam int S = 1 << k;
    assign stage[k+1] = shift_amount[k] ? {{S{fill}}, stage[k][31:S]} : stage[k];
  end

  assign result = right ? stage[5] : reverse32(stage[5]);

  // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh <= '0;
    end else begin
      sh <= result;
    end
  end

endmodule

// File: tb/tb_shift.sv
// Self-checking bench for shift: directed vector table, reset/latency sequences,
// and a randomised comparison against the language shift operators.
module tb_shift;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] sh;
  logic [31:0] data;
  logic [4:0]  shift_amount;
  logic        right;
  logic        arithmetic;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] data;
    logic [4:0]  amount;
    logic        right;
    logic        arithmetic;
    logic [31:0] expected;
  } vec_t;

  vec_t vecs[$];

  shift dut (
    .clk          (clk),
    .reset        (reset),
    .sh           (sh),
    .data         (data),
    .shift_amount (shift_amount),
    .right        (right),
    .arithmetic   (arithmetic)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("FAIL %s: got %08h expected %08h", name, actual, expected);
    end
  endtask

  task automatic drive(input logic [31:0] d, input logic [4:0] a, input logic r, input logic ar);
    data         = d;
    shift_amount = a;
    right        = r;
    arithmetic   = ar;
  endtask

  function automatic logic [31:0] ref_shift(input logic [31:0] d, input logic [4:0] a,
                                            input logic r, input logic ar);
    if (!r)      return d << a;
    else if (ar) return $unsigned($signed(d) >>> a);
    else         return d >> a;
  endfunction

  initial begin
    logic [31:0] sra_exp [8];
    logic [31:0] srl_exp [8];
    logic [31:0] sll_exp [8];
    logic [31:0] d;
    logic [4:0]  a;
    logic        r, ar;

    sra_exp = '{32'hFFF0_000F, 32'hFFFF_0000, 32'hFFFF_F000, 32'hFFFF_FF00,
                32'hFFFF_FFF0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    srl_exp = '{32'h0FF0_000F, 32'h00FF_0000, 32'h000F_F000, 32'h0000_FF00,
                32'h0000_0FF0, 32'h0000_00FF, 32'h0000_000F, 32'h0000_0001};
    sll_exp = '{32'hF000_0FF0, 32'h0000_FF00, 32'h000F_F000, 32'h00FF_0000,
                32'h0FF0_0000, 32'hFF00_0000, 32'hF000_0000, 32'h8000_0000};

    for (int i = 0; i < 8; i++) begin
      logic [4:0] amt;
      amt = (i == 7) ? 5'd31 : 5'(4 * (i + 1));
      vecs.push_back('{32'hFF00_00FF, amt, 1'b1, 1'b1, sra_exp[i]});
      vecs.push_back('{32'hFF00_00FF, amt, 1'b1, 1'b0, srl_exp[i]});
      vecs.push_back('{32'hFF00_00FF, amt, 1'b0, 1'b1, sll_exp[i]});
      vecs.push_back('{32'hFF00_00FF, amt, 1'b0, 1'b0, sll_exp[i]});
    end
    vecs.push_back('{32'h8000_0001, 5'd0,  1'b0, 1'b0, 32'h8000_0001});
    vecs.push_back('{32'h8000_0001, 5'd0,  1'b1, 1'b0, 32'h8000_0001});
    vecs.push_back('{32'h8000_0001, 5'd0,  1'b1, 1'b1, 32'h8000_0001});
    vecs.push_back('{32'h7FFF_FFFF, 5'd31, 1'b1, 1'b1, 32'h0000_0000});
    vecs.push_back('{32'h8000_0000, 5'd1,  1'b1, 1'b1, 32'hC000_0000});
    vecs.push_back('{32'h8000_0000, 5'd31, 1'b1, 1'b1, 32'hFFFF_FFFF});
    vecs.push_back('{32'h1234_5678, 5'd3,  1'b0, 1'b0, 32'h91A2_B3C0});
    vecs.push_back('{32'h1234_5678, 5'd5,  1'b1, 1'b1, 32'h0091_A2B3});

    // Power-on reset with nonzero inputs applied.
    reset = 1'b1;
    drive(32'hDEAD_BEEF, 5'd3, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1 check("reset_state", sh, 32'h0);

    // Directed table, one new vector every cycle.
    @(negedge clk);
    reset = 1'b0;
    foreach (vecs[i]) begin
      drive(vecs[i].data, vecs[i].amount, vecs[i].right, vecs[i].arithmetic);
      @(posedge clk);
      #1 check($sformatf("vec%0d", i), sh, vecs[i].expected);
      @(negedge clk);
    end

    // Mid-stream reset: output holds until the edge, then clears despite live inputs.
    drive(32'h0000_00F0, 5'd4, 1'b0, 1'b0);
    @(posedge clk);
    #1 check("pre_reset_value", sh, 32'h0000_0F00);
    @(negedge clk);
    reset = 1'b1;
    drive(32'hFFFF_FFFF, 5'd1, 1'b1, 1'b1);
    #1 check("reset_is_synchronous", sh, 32'h0000_0F00);
    @(posedge clk);
    #1 check("reset_clears", sh, 32'h0);

    // First edge after deassertion captures the current inputs.
    @(negedge clk);
    reset = 1'b0;
    drive(32'hA5A5_0000, 5'd8, 1'b1, 1'b0);
    #1 check("hold_zero_before_edge", sh, 32'h0);
    @(posedge clk);
    #1 check("first_after_reset", sh, 32'h00A5_A500);

    // Randomised comparison against the reference operators.
    for (int n = 0; n < 10000; n++) begin
      @(negedge clk);
      d  = $urandom;
      a  = 5'($urandom_range(0, 31));
      r  = 1'($urandom_range(0, 1));
      ar = 1'($urandom_range(0, 1));
      drive(d, a, r, ar);
      @(posedge clk);
      #1 check($sformatf("rand%0d d=%08h a=%0d r=%0b ar=%0b", n, d, a, r, ar),
               sh, ref_shift(d, a, r, ar));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
